// File: rtl/piped_mod_subtractor.sv
// Pipelined modular subtractor, out0 = (in0 - in1) mod Q, one borrow chunk per stage.
// Define PIPED_MOD_SUB_REDUCE_EN to add the chunked add-back-of-Q phase; otherwise mod 2^W.
module piped_mod_subtractor #(
  parameter int           W = 384,
  parameter int           C = 1,
  parameter int           M = 1,
  parameter logic [W-1:0] Q = 384'h01ae3a4617c510eac63b05c06ca1493b1a22d9f300f5138f1ef3622fba094800170b5d44300000008508c00000000001
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  input  logic [M-1:0] m_i,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out0,
  output logic [M-1:0] m_o,
  output logic         borrow_o
);
  localparam int D  = 2 ** C;
  localparam int CW = W / D;
  localparam int LW = W - (D - 1) * CW;

  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  genvar gi;

  // Subtract phase: stage gi consumes chunk gi of a/b and passes the unconsumed upper bits on.
  for (gi = 0; gi < D; gi++) begin : g_sub
    localparam int LO = gi * CW;
    localparam int WK = (gi == D - 1) ? LW : CW;
    localparam int HI = W - LO;

    logic [HI-1:0]    a_in;
    logic [HI-1:0]    b_in;
    logic             bw_in;
    logic             v_in;
    logic [M-1:0]     m_in;
    logic [WK:0]      dif;
    logic [LO+WK-1:0] d_next;
    logic [LO+WK-1:0] d_reg;
    logic             bw_reg;
    logic             v_reg;
    logic [M-1:0]     m_reg;

    assign dif = {1'b0, a_in[WK-1:0]} - {1'b0, b_in[WK-1:0]} - {{WK{1'b0}}, bw_in};

    if (gi == 0) begin : g_src
      assign a_in   = in0;
      assign b_in   = in1;
      assign bw_in  = 1'b0;
      assign v_in   = in_valid;
      assign m_in   = m_i;
      assign d_next = dif[WK-1:0];
    end else begin : g_src
      assign a_in   = g_sub[gi-1].g_hi.a_reg;
      assign b_in   = g_sub[gi-1].g_hi.b_reg;
      assign bw_in  = g_sub[gi-1].bw_reg;
      assign v_in   = g_sub[gi-1].v_reg;
      assign m_in   = g_sub[gi-1].m_reg;
      assign d_next = {dif[WK-1:0], g_sub[gi-1].d_reg};
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        d_reg  <= '0;
        bw_reg <= 1'b0;
        v_reg  <= 1'b0;
        m_reg  <= '0;
      end else if (en) begin
        d_reg  <= d_next;
        bw_reg <= dif[WK];
        v_reg  <= v_in;
        m_reg  <= m_in;
      end
    end

    if (gi < D - 1) begin : g_hi
      logic [HI-WK-1:0] a_reg;
      logic [HI-WK-1:0] b_reg;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          a_reg <= '0;
          b_reg <= '0;
        end else if (en) begin
          a_reg <= a_in[HI-1:WK];
          b_reg <= b_in[HI-1:WK];
        end
      end
    end
  end

`ifdef PIPED_MOD_SUB_REDUCE_EN
  // Mod phase: add (borrow ? Q : 0) chunkwise; the carry out of the top chunk is dropped.
  for (gi = 0; gi < D; gi++) begin : g_mod
    localparam int LO = gi * CW;
    localparam int WK = (gi == D - 1) ? LW : CW;
    localparam int SW = (gi == D - 1) ? WK : WK + 1;

    logic [W-1:0]  r_in;
    logic          bw_in;
    logic          v_in;
    logic          cy_in;
    logic [M-1:0]  m_in;
    logic [WK-1:0] q_chunk;
    logic [SW-1:0] sum;
    logic [W-1:0]  r_next;
    logic [W-1:0]  r_reg;
    logic          bw_reg;
    logic          v_reg;
    logic [M-1:0]  m_reg;

    if (gi == 0) begin : g_src
      assign r_in  = g_sub[D-1].d_reg;
      assign bw_in = g_sub[D-1].bw_reg;
      assign v_in  = g_sub[D-1].v_reg;
      assign m_in  = g_sub[D-1].m_reg;
      assign cy_in = 1'b0;
    end else begin : g_src
      assign r_in  = g_mod[gi-1].r_reg;
      assign bw_in = g_mod[gi-1].bw_reg;
      assign v_in  = g_mod[gi-1].v_reg;
      assign m_in  = g_mod[gi-1].m_reg;
      assign cy_in = g_mod[gi-1].g_cy.cy_reg;
    end

    assign q_chunk = bw_in ? Q[LO +: WK] : '0;
    assign sum     = SW'(r_in[LO +: WK]) + SW'(q_chunk) + SW'(cy_in);

    always_comb begin
      r_next            = r_in;
      r_next[LO +: WK]  = sum[WK-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_reg  <= '0;
        bw_reg <= 1'b0;
        v_reg  <= 1'b0;
        m_reg  <= '0;
      end else if (en) begin
        r_reg  <= r_next;
        bw_reg <= bw_in;
        v_reg  <= v_in;
        m_reg  <= m_in;
      end
    end

    if (gi < D - 1) begin : g_cy
      logic cy_reg;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          cy_reg <= 1'b0;
        end else if (en) begin
          cy_reg <= sum[SW-1];
        end
      end
    end
  end

  assign out_valid = g_mod[D-1].v_reg;
  assign out0      = g_mod[D-1].r_reg;
  assign m_o       = g_mod[D-1].m_reg;
  assign borrow_o  = g_mod[D-1].bw_reg;
`else
  assign out_valid = g_sub[D-1].v_reg;
  assign out0      = g_sub[D-1].d_reg;
  assign m_o       = g_sub[D-1].m_reg;
  assign borrow_o  = g_sub[D-1].bw_reg;
`endif

endmodule

// File: tb/tb_piped_mod_subtractor.sv
// Randomized and directed bench for piped_mod_subtractor (W=8, C=1, Q=13),
// following PIPED_MOD_SUB_REDUCE_EN for the expected arithmetic and latency.
module tb_piped_mod_subtractor;
  localparam int W  = 8;
  localparam int C  = 1;
  localparam int M  = 4;
  localparam int QV = 13;
`ifdef PIPED_MOD_SUB_REDUCE_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in0 = '0;
  logic [W-1:0] in1 = '0;
  logic [M-1:0] m_i = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out0;
  logic [M-1:0] m_o;
  logic         borrow_o;

  typedef struct {
    logic [7:0] d;
    logic       bw;
    logic [3:0] m;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  bit   lat_on   = 1'b1;
  bit   bp_done  = 1'b0;

  piped_mod_subtractor #(.W(W), .C(C), .M(M), .Q(8'd13)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in0       (in0),
    .in1       (in1),
    .m_i       (m_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out0      (out0),
    .m_o       (m_o),
    .borrow_o  (borrow_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: field subtraction for in-range operands, otherwise raw difference plus borrow*Q.
  function automatic exp_t model(input int a, input int b, input int m);
    exp_t r;
    r.bw = (a < b);
    r.m  = 4'(m);
`ifdef PIPED_MOD_SUB_REDUCE_EN
    if (a < QV && b < QV) r.d = 8'((a - b + QV) % QV);
    else                  r.d = 8'(a - b + (a < b ? QV : 0));
`else
    r.d = 8'(a - b);
`endif
    r.cyc = cyc;
    return r;
  endfunction

  // Scoreboard: every valid output is compared with the oldest outstanding beat.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check_value("spurious_out", 32'(out_valid), 32'd0);
        end else begin
          check_value("out0", 32'(out0), 32'(exp_q[0].d));
          check_value("borrow_o", 32'(borrow_o), 32'(exp_q[0].bw));
          check_value("m_o", 32'(m_o), 32'(exp_q[0].m));
          if (out_ready) begin
            if (lat_on) check_value("latency", 32'(cyc - exp_q[0].cyc), 32'(LAT));
            $display("beat out: out0=%0d borrow=%0d tag=%0d", out0, borrow_o, m_o);
            void'(exp_q.pop_front());
          end
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(int'(in0), int'(in1), int'(m_i)));
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] m);
    int n = 0;
    in0 = a; in1 = b; m_i = m; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check_value("send_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_value("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [7:0] ra, rb;

    // Reset state
    #1 rst = 1'b0;
    #1;
    check_value("rst_out_valid", 32'(out_valid), 32'd0);
    check_value("rst_out0", 32'(out0), 32'd0);
    check_value("rst_m_o", 32'(m_o), 32'd0);
    check_value("rst_borrow_o", 32'(borrow_o), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1 check_value("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Directed single beats, including the borrow and operand-equals-boundary cases
    send(8'd5, 8'd3, 4'd1);   drain();
    send(8'd3, 8'd5, 4'd2);   drain();
    send(8'd12, 8'd12, 4'd3); drain();
    send(8'd0, 8'd12, 4'd4);  drain();
    send(8'd12, 8'd0, 4'd5);  drain();

    // Back-to-back stream at full throughput
    for (int i = 0; i < 8; i++) send(8'(i), 8'd7, 4'(i));
    drain();

    // Same stream with a 5-cycle backpressure stall after the first output
    lat_on = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) send(8'(i), 8'd7, 4'(i));
      end
      begin
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 50) begin
          @(negedge clk);
          n++;
        end
        check_value("first_out_seen", 32'(out_valid), 32'd1);
        @(posedge clk); #1 out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check_value("stall_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    drain();

    // Asynchronous reset with beats in flight and the output stalled
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in0 = 8'(i + 4); in1 = 8'd2; m_i = 4'(i + 9); in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    check_value("async_rst_out_valid", 32'(out_valid), 32'd0);
    check_value("async_rst_out0", 32'(out0), 32'd0);
    check_value("async_rst_m_o", 32'(m_o), 32'd0);
    exp_q.delete();
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1 check_value("post_rst_in_ready", 32'(in_ready), 32'd1);
    repeat (6) begin
      @(negedge clk);
      check_value("post_rst_idle", 32'(out_valid), 32'd0);
    end
    @(posedge clk); #1;

    // Random beats, no backpressure, random idle gaps; mostly in-range operands
    lat_on = 1'b1;
    for (int i = 0; i < 40; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, QV - 1));
      rb = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, QV - 1));
      send(ra, rb, 4'($urandom_range(0, 15)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    drain();

    // Random beats under random backpressure
    lat_on = 1'b0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          ra = 8'($urandom_range(0, QV - 1));
          rb = 8'($urandom_range(0, QV - 1));
          send(ra, rb, 4'($urandom_range(0, 15)));
          if ($urandom_range(0, 2) == 0) begin
            @(posedge clk); #1;
          end
        end
        bp_done = 1'b1;
      end
      begin
        while (!bp_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
